// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver: two-flop rx synchroniser, mid-bit sampling FSM, and a
// small byte FIFO with valid/ready output, framing-error pulse and sticky overflow.
module uart_rx_fifo #(
  parameter int DIVISOR = 723,
  parameter int DEPTH   = 16
) (
  input  logic                   clock,
  input  logic                   RST_N,
  input  logic                   rx,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overflow,
  input  logic                   clear_err
);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge on rx_s
  // START  | timing to the middle of the start bit to reject glitches
  // DATA   | sampling eight data bits, LSB first, once per bit period
  // STOP   | sampling the stop bit; good byte is pushed here
  // BREAK  | bad stop bit seen, waiting for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam int CW = $clog2(DIVISOR);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic          push_req;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push into a full FIFO still lands when a pop frees the head in the same cycle.
  always_comb begin
    pop     = out_valid && out_ready;
    full    = (count == DEPTH_P);
    do_push = push_req && (!full || pop);
    drop    = push_req && full && !pop;

    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = shift_q;

    overflow_d = overflow_q;
    if (clear_err) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mem_q       <= mem_d;
    end
  end

  assign count     = wr_q - rd_q;
  assign out_valid = (wr_q != rd_q);
  assign out_data  = mem_q[rd_q[AW-1:0]];
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame-level reference model with a byte
// queue, per-cycle output comparison, directed scenarios and randomized traffic.
module tb_uart_rx_fifo;

  localparam int D   = 16;
  localparam int DEP = 4;
  localparam int H   = D / 2;
  // Edges from driving the start bit low to the stop-bit sample:
  // 2 synchroniser + 1 idle detect + half bit + 8 data bits + stop bit.
  localparam int LAT = 3 + H + 9 * D;
  localparam int FRAME = 10 * D;

  logic       clock = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overflow;

  uart_rx_fifo #(.DIVISOR(D), .DEPTH(DEP)) dut (
    .clock     (clock),
    .RST_N     (RST_N),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clear_err (clear_err)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;
  bit rand_rdy = 1'b0;
  int rdy_pct = 50;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         good;
  } ev_t;

  ev_t        ev[$];
  logic [7:0] mq[$];
  bit         movf = 1'b0;
  bit         mferr = 1'b0;

  int         ferr_pulses = 0;
  int         valid_cycles = 0;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue updated once per clock edge from frame events.
  always @(posedge clock) begin
    bit         do_pop;
    bit         have_push;
    logic [7:0] pb;
    ev_t        e;
    cyc = cyc + 1;
    if (!RST_N) begin
      mq.delete();
      ev.delete();
      movf  = 1'b0;
      mferr = 1'b0;
    end else begin
      mferr     = 1'b0;
      have_push = 1'b0;
      pb        = 8'h00;
      do_pop    = (mq.size() > 0) && out_ready;
      while (ev.size() > 0 && ev[0].at == cyc) begin
        e = ev.pop_front();
        if (e.good) begin
          have_push = 1'b1;
          pb        = e.d;
        end else begin
          mferr = 1'b1;
        end
      end
      if (clear_err) movf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (have_push) begin
        if (mq.size() >= DEP) movf = 1'b1;
        else                  mq.push_back(pb);
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("count", count, mq.size());
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("frame_err", frame_err, mferr);
      chk("overflow", overflow, movf);
      if (frame_err) ferr_pulses++;
      if (out_valid) valid_cycles++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) popped.push_back(out_data);
    end
  end

  task automatic randomize_ctrl();
    if (rand_rdy) begin
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      clear_err = ($urandom_range(0, 40) == 0);
    end
  endtask

  task automatic idle(input int k);
    rx = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(posedge clock);
      #1;
      randomize_ctrl();
    end
  endtask

  // Drives one frame (or its first len cycles); a full-length frame is scheduled
  // into the model at its stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pulse,
                            input int len, output int n);
    int slot;
    @(posedge clock);
    #1;
    n = cyc;
    if (len == FRAME) ev.push_back('{at: n + LAT, d: b, good: stop});
    for (int t = 0; t < len; t++) begin
      if (t > 0) begin
        @(posedge clock);
        #1;
      end
      slot = t / D;
      if (slot == 0)      rx = 1'b0;
      else if (slot <= 8) rx = b[slot-1];
      else                rx = stop;
      randomize_ctrl();
      if (pulse && t == LAT - 1) out_ready = 1'b1;
      if (pulse && t == LAT)     out_ready = 1'b0;
    end
  endtask

  task automatic drain(input int k);
    out_ready = 1'b1;
    idle(k);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int f0;
    logic [7:0] b;
    bit st;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_count", count, 3'd0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    chk_en = 1'b1;
    @(posedge clock);
    #1;
    RST_N = 1'b1;
    idle(5);

    // Single good byte with consumer always ready.
    out_ready = 1'b1;
    popped.delete();
    valid_cycles = 0;
    f0 = ferr_pulses;
    send_frame(8'hA5, 1'b1, 1'b0, FRAME, n);
    idle(20);
    chk("a5_latency", rise_cyc - n, LAT);
    chk("a5_count", popped.size(), 1);
    chk("a5_data", popped.size() > 0 ? popped[0] : 8'hxx, 8'hA5);
    chk("a5_valid_cycles", valid_cycles, 1);
    chk("a5_no_ferr", ferr_pulses - f0, 0);

    // Start-bit glitch shorter than half a bit.
    popped.delete();
    f0 = ferr_pulses;
    @(posedge clock);
    #1;
    rx = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    idle(40);
    chk("glitch_no_push", popped.size(), 0);
    chk("glitch_no_ferr", ferr_pulses - f0, 0);

    // Bad stop bit followed by a long low line, then a good frame.
    f0 = ferr_pulses;
    send_frame(8'h3C, 1'b0, 1'b0, FRAME, n);
    repeat (40) begin
      @(posedge clock);
      #1;
    end
    idle(20);
    chk("break_one_ferr", ferr_pulses - f0, 1);
    chk("break_count", count, 3'd0);
    popped.delete();
    send_frame(8'h11, 1'b1, 1'b0, FRAME, n);
    idle(20);
    chk("after_break_n", popped.size(), 1);
    chk("after_break_data", popped.size() > 0 ? popped[0] : 8'hxx, 8'h11);

    // Overflow with consumer stalled, then clear and drain.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, 1'b0, FRAME, n);
    end
    idle(20);
    chk("ovf_count", count, 3'd4);
    chk("ovf_head", out_data, 8'h01);
    chk("ovf_flag", overflow, 1'b1);
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
    @(negedge clock);
    chk("ovf_cleared", overflow, 1'b0);
    popped.delete();
    drain(10);
    chk("ovf_drain_n", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("ovf_drain_data", i < popped.size() ? popped[i] : 8'hxx, 8'(i + 1));

    // Push into a full FIFO with a simultaneous pop.
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, 1'b0, FRAME, n);
    end
    send_frame(8'h05, 1'b1, 1'b1, FRAME, n);
    idle(20);
    chk("simul_count", count, 3'd4);
    chk("simul_overflow", overflow, 1'b0);
    popped.delete();
    drain(10);
    chk("simul_drain_n", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("simul_drain_data", i < popped.size() ? popped[i] : 8'hxx, 8'(i + 2));

    // Reset in the middle of a data bit with two bytes buffered.
    send_frame(8'hAA, 1'b1, 1'b0, FRAME, n);
    send_frame(8'h55, 1'b1, 1'b0, FRAME, n);
    idle(5);
    send_frame(8'hC3, 1'b1, 1'b0, 60, n);
    @(posedge clock);
    #1;
    RST_N = 1'b0;
    rx = 1'b1;
    @(posedge clock);
    #1;
    RST_N = 1'b1;
    @(negedge clock);
    chk("midrst_count", count, 3'd0);
    chk("midrst_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    idle(5);
    popped.delete();
    send_frame(8'h7E, 1'b1, 1'b0, FRAME, n);
    idle(20);
    chk("midrst_next_n", popped.size(), 1);
    chk("midrst_next_data", popped.size() > 0 ? popped[0] : 8'hxx, 8'h7E);

    // Randomized traffic with random consumer stalls, stop-bit errors and clears.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       rdy_pct = 0;
        1:       rdy_pct = 2;
        default: rdy_pct = 50;
      endcase
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      send_frame(b, st, 1'b0, FRAME, n);
      idle($urandom_range(2, 6));
    end
    rand_rdy = 1'b0;
    clear_err = 1'b0;
    drain(30);
    chk("final_empty", count, 3'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end that drives the byte-stream input of the core's UART path; sits directly downstream of the board rx pin.
- Synchronises rx, decodes 8N1 frames with a programmable bit divisor, and buffers bytes in a small FIFO with a valid/ready output.
- Reports framing errors and FIFO overflow.

Parameters:
- DIVISOR, 723, clock cycles per bit (83.33 MHz / 115200); must be >= 4.
- DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single clock; every register is in this domain.
- RST_N  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head byte when out_valid && out_ready.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse when a bad stop bit is sampled.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- clear_err  in  1  clears overflow.

Behaviour:
- Reset (RST_N=0 at a clock edge): sync flops=1, FSM=IDLE, counters=0, FIFO empty. Outputs: out_valid=0, count=0, frame_err=0, overflow=0, out_data=0.
- Synchroniser: two flops give rx_s. Detection latency is 2 cycles after rx changes.
- Bit counter cnt is $clog2(DIVISOR) bits wide. bit_idx counts 0..7.
- IDLE: if rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==DIVISOR/2-1 (integer division), sample rx_s:
  - rx_s==1: glitch; return to IDLE with no output.
  - rx_s==0: cnt=0, bit_idx=0, go to DATA.
- DATA: cnt counts 0..DIVISOR-1. At cnt==DIVISOR-1, sample rx_s into shift[bit_idx] (LSB first) and set cnt=0. After bit_idx==7 is sampled, go to STOP.
- STOP: at cnt==DIVISOR-1, sample rx_s:
  - rx_s==1: push the byte and go to IDLE.
  - rx_s==0: pulse frame_err for exactly 1 cycle, discard the byte, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A continuous low line yields one frame_err only.
- Push: occurs in the same cycle as the stop sample. The byte becomes visible on out_data/out_valid the next cycle. There is no bypass path.
- Push when full:
  - Without a simultaneous pop: byte dropped, overflow set to 1.
  - With a simultaneous pop: both the pop and the push happen, count is unchanged, overflow is not set.
- Pop when empty: ignored. out_data must not change while out_valid && !out_ready.
- Pointers: wrap modulo DEPTH. count = wr - rd using $clog2(DEPTH)+1-bit pointers; full when count==DEPTH.
- overflow: cleared by clear_err. If clear_err and a drop occur in the same cycle, set wins (overflow=1).
- Reset mid-frame: FSM aborts to IDLE, FIFO empties, the partial byte is never delivered.
- rx changes between samples have no effect; there is no majority voting.

Test Plan (DIVISOR=16, DEPTH=4):
- Send 0xA5 (8N1), out_ready=1 -> out_valid rises 1 cycle after the stop sample with out_data=0xA5 and stays high 1 cycle; frame_err stays 0.
- rx low for 4 cycles then high -> START aborts at the mid-bit sample; no push, no frame_err, FSM back in IDLE.
- Send 0x3C with stop bit 0, then rx held low 40 cycles -> exactly one frame_err pulse, count=0; next good frame 0x11 is received correctly.
- out_ready=0, send 5 bytes 0x01..0x05 -> count=4, out_data=0x01, overflow=1 after the 5th byte; assert clear_err -> overflow=0; drain yields 0x01,0x02,0x03,0x04.
- FIFO full, pulse out_ready in the same cycle as the 5th stop sample -> count stays 4, overflow=0, drain yields 0x02..0x05.
- Drop RST_N for 1 cycle mid-DATA with 2 bytes buffered -> next cycle count=0, out_valid=0; the following full frame 0x7E is received correctly.
